// File: rtl/if_prefetch.sv
// Instruction fetch unit: icache lookup or multi-beat memory fill,
// buffered through a prefetch FIFO toward IF/ID.
module if_prefetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BUS_BYTES  = 1,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [8*BUS_BYTES-1:0]   mem_rdata,
  output logic [31:0]              icache_raddr,
  input  logic                     icache_hit,
  input  logic [31:0]              icache_rdata,
  output logic                     icache_we,
  output logic [31:0]              icache_waddr,
  output logic [31:0]              icache_wdata,
  input  logic                     branch_en,
  input  logic [31:0]              branch_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst
);
  localparam int unsigned NB = 4 / BUS_BYTES;
  localparam int unsigned BW = 8 * BUS_BYTES;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {LOOKUP, REQ, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [1:0]    beat_q, beat_d;
  logic [31:0]   asm_q, asm_d;
  logic [4:0]    boff;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          push, pop, flush, room, empty, full, fill_d;
  logic [31:0]   push_inst;

  always_comb begin
    empty        = (cnt_q == '0);
    full         = (cnt_q == (AW+1)'(FIFO_DEPTH));
    out_valid    = !empty && !branch_en;
    pop          = out_valid && out_ready;
    room         = !full || pop;
    out_pc       = fifo_pc[rptr_q];
    out_inst     = fifo_inst[rptr_q];
    icache_raddr = pc_q;
    mem_req      = (state_q == REQ);
    mem_addr     = mem_req ? pc_q + 32'(beat_q) * 32'(BUS_BYTES) : '0;
    boff         = 5'(32'(beat_q) * BW);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    beat_d    = beat_q;
    asm_d     = asm_q;
    push      = 1'b0;
    fill_d    = 1'b0;
    push_inst = icache_rdata;
    flush     = branch_en;
    unique case (state_q)
      LOOKUP: begin
        if (room) begin
          if (icache_hit) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end else begin
            beat_d  = '0;
            state_d = REQ;
          end
        end
      end
      REQ: if (mem_gnt) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          asm_d[boff +: BW] = mem_rdata;
          if (beat_q == 2'(NB - 1)) begin
            push      = 1'b1;
            fill_d    = 1'b1;
            push_inst = asm_d;
            pc_d      = pc_q + 32'd4;
            state_d   = LOOKUP;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = REQ;
          end
        end
      end
      DRAIN: if (mem_rvalid) state_d = LOOKUP;
      default: state_d = LOOKUP;
    endcase
    // Redirect wins; a granted or pending beat must still be absorbed
    if (branch_en) begin
      push   = 1'b0;
      fill_d = 1'b0;
      pc_d   = branch_addr & 32'hFFFF_FFFC;
      beat_d = '0;
      unique case (state_q)
        REQ:     state_d = mem_gnt ? DRAIN : LOOKUP;
        WAIT:    state_d = mem_rvalid ? LOOKUP : DRAIN;
        DRAIN:   state_d = mem_rvalid ? LOOKUP : DRAIN;
        default: state_d = LOOKUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOOKUP;
      pc_q         <= RESET_PC;
      beat_q       <= '0;
      asm_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      icache_we    <= 1'b0;
      icache_waddr <= '0;
      icache_wdata <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      beat_q    <= beat_d;
      asm_q     <= asm_d;
      icache_we <= fill_d;
      if (fill_d) begin
        icache_waddr <= pc_q;
        icache_wdata <= push_inst;
      end
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop)  rptr_q <= rptr_q + AW'(1);
        cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wptr_q]   <= pc_q;
      fifo_inst[wptr_q] <= push_inst;
    end
  end
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: byte-bus instance plus
// a word-bus instance with a manually driven memory port.
module tb_if_prefetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        rst_n, mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] ic_raddr, ic_rdata, ic_waddr, ic_wdata;
  logic        ic_hit, ic_we, br_en, out_valid, out_ready;
  logic [31:0] br_addr, out_pc, out_inst;
  logic        hit_en, gnt_en, rv_block;
  logic [31:0] miss_addr;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          we_cnt = 0;

  logic        rst4_n, req4, gnt4, rv4, we4, ov4;
  logic [31:0] addr4, rdata4, raddr4, waddr4, wdata4, pc4, inst4;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102, 32'h103: return 8'h00;
      default: return a[7:0];
    endcase
  endfunction

  assign ic_hit     = hit_en && (ic_raddr != miss_addr);
  assign ic_rdata   = ~ic_raddr;
  assign mem_gnt    = mem_req && gnt_en;
  assign mem_rvalid = pend && !rv_block;
  assign mem_rdata  = mem_byte(pend_addr);

  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      pend      <= 1'b1;
      pend_addr <= mem_addr;
    end else if (mem_rvalid) begin
      pend <= 1'b0;
    end
    if (ic_we) we_cnt <= we_cnt + 1;
  end

  if_prefetch #(.FIFO_DEPTH(4), .BUS_BYTES(1), .RESET_PC(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .icache_raddr(ic_raddr), .icache_hit(ic_hit), .icache_rdata(ic_rdata),
    .icache_we(ic_we), .icache_waddr(ic_waddr), .icache_wdata(ic_wdata),
    .branch_en(br_en), .branch_addr(br_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  if_prefetch #(.FIFO_DEPTH(4), .BUS_BYTES(4), .RESET_PC(32'h1000)) u4 (
    .clk(clk), .rst_n(rst4_n),
    .mem_req(req4), .mem_addr(addr4), .mem_gnt(gnt4),
    .mem_rvalid(rv4), .mem_rdata(rdata4),
    .icache_raddr(raddr4), .icache_hit(1'b0), .icache_rdata(32'h0),
    .icache_we(we4), .icache_waddr(waddr4), .icache_wdata(wdata4),
    .branch_en(1'b0), .branch_addr(32'h0),
    .out_valid(ov4), .out_ready(1'b0),
    .out_pc(pc4), .out_inst(inst4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !out_valid; i++) tick();
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a,
                          input int budget);
    for (int i = 0; i < budget && !(mem_req && mem_addr == a); i++)
      tick();
    chk(tag, mem_addr, a);
  endtask

  initial begin
    logic [31:0] ga[$];
    logic [31:0] e;
    int w0;
    rst_n = 1'b0; rst4_n = 1'b0;
    hit_en = 1'b1; gnt_en = 1'b1; rv_block = 1'b0;
    miss_addr = 32'hFFFF_FFF0;
    br_en = 1'b0; br_addr = 32'h0; out_ready = 1'b1;
    gnt4 = 1'b0; rv4 = 1'b0; rdata4 = 32'h0;
    tick(); tick();

    // reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_we", 32'(ic_we), 32'd0);
    chk("rst_raddr", ic_raddr, 32'h0);
    chk("rst4_req", 32'(req4), 32'd0);

    // all-hit streaming
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = 32'(4 * i);
      chk("hit_valid", 32'(out_valid), 32'd1);
      chk("hit_pc", out_pc, e);
      chk("hit_inst", out_inst, ~e);
      chk("hit_noreq", 32'(mem_req), 32'd0);
    end

    // stall: FIFO fills to 4 and holds
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("stall_pc", out_pc, 32'd12);
    chk("stall_raddr", ic_raddr, 32'd28);
    chk("stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = 32'(16 + 4 * i);
      chk("drain_pc", out_pc, e);
      chk("drain_inst", out_inst, ~e);
    end

    // miss at 0x100, byte beats
    w0 = we_cnt;
    miss_addr = 32'h100; br_addr = 32'h100; br_en = 1'b1;
    #1;
    chk("br_mask", 32'(out_valid), 32'd0);
    tick();
    br_en = 1'b0;
    #1;
    chk("br_raddr", ic_raddr, 32'h100);
    chk("br_empty", 32'(out_valid), 32'd0);
    ga = {};
    for (int i = 0; i < 40 && !out_valid; i++) begin
      if (mem_req && mem_gnt) ga.push_back(mem_addr);
      tick();
    end
    chk("miss_valid", 32'(out_valid), 32'd1);
    chk("miss_nbeats", 32'(ga.size()), 32'd4);
    foreach (ga[i]) chk("miss_beat_addr", ga[i], 32'h100 + 32'(i));
    chk("miss_pc", out_pc, 32'h100);
    chk("miss_inst", out_inst, 32'h0000_0513);
    chk("fill_we", 32'(ic_we), 32'd1);
    chk("fill_addr", ic_waddr, 32'h100);
    chk("fill_data", ic_wdata, 32'h0000_0513);
    tick();
    chk("fill_pulse", 32'(ic_we), 32'd0);
    chk("fill_once", 32'(we_cnt), 32'(w0 + 1));

    // redirect while waiting for beat 2
    out_ready = 1'b0; miss_addr = 32'h190;
    br_addr = 32'h184; br_en = 1'b1;
    tick();
    br_en = 1'b0;
    wait_req("b4_req", 32'h192, 30);
    rv_block = 1'b1;
    tick();
    tick();
    chk("b4_wait_noreq", 32'(mem_req), 32'd0);
    chk("b4_head", out_pc, 32'h184);
    w0 = we_cnt;
    br_addr = 32'h203; br_en = 1'b1;
    #1;
    chk("b4_mask", 32'(out_valid), 32'd0);
    tick();
    br_en = 1'b0; miss_addr = 32'h200; out_ready = 1'b1; rv_block = 1'b0;
    #1;
    chk("b4_flush", 32'(out_valid), 32'd0);
    chk("b4_raddr", ic_raddr, 32'h200);
    chk("b4_drain_noreq", 32'(mem_req), 32'd0);
    tick();
    chk("b4_ate_req", 32'(mem_req), 32'd0);
    chk("b4_ate_valid", 32'(out_valid), 32'd0);
    tick();
    chk("b4_new_req", 32'(mem_req), 32'd1);
    chk("b4_new_addr", mem_addr, 32'h200);
    chk("b4_no_fill", 32'(we_cnt), 32'(w0));
    wait_valid("b4_valid", 30);
    chk("b4_pc", out_pc, 32'h200);
    chk("b4_inst", out_inst, 32'h0302_0100);

    // reset in WAIT, stray rvalid afterwards
    miss_addr = 32'h300; br_addr = 32'h300; br_en = 1'b1;
    tick();
    br_en = 1'b0;
    wait_req("r6_req", 32'h300, 10);
    rv_block = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("r6_req_low", 32'(mem_req), 32'd0);
    chk("r6_valid_low", 32'(out_valid), 32'd0);
    chk("r6_raddr", ic_raddr, 32'h0);
    tick();
    w0 = we_cnt;
    rst_n = 1'b1; rv_block = 1'b0;
    tick();
    chk("r6_pc0", out_pc, 32'h0);
    chk("r6_inst0", out_inst, 32'hFFFF_FFFF);
    chk("r6_noreq", 32'(mem_req), 32'd0);
    tick();
    chk("r6_pc4", out_pc, 32'h4);
    chk("r6_no_fill", 32'(we_cnt), 32'(w0));

    // pc wraps at the top of the address space
    br_addr = 32'hFFFF_FFF8; br_en = 1'b1;
    tick();
    br_en = 1'b0;
    tick();
    chk("wrap_a", out_pc, 32'hFFFF_FFF8);
    tick();
    chk("wrap_b", out_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_c", out_pc, 32'h0);

    // word bus, grant held off 5 cycles
    rst4_n = 1'b1;
    tick();
    chk("w_req", 32'(req4), 32'd1);
    chk("w_raddr", raddr4, 32'h1000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w_hold_req", 32'(req4), 32'd1);
      chk("w_hold_addr", addr4, 32'h1000);
    end
    gnt4 = 1'b1;
    tick();
    gnt4 = 1'b0;
    #1;
    chk("w_wait", 32'(req4), 32'd0);
    rv4 = 1'b1; rdata4 = 32'hDEAD_BEEF;
    tick();
    rv4 = 1'b0;
    #1;
    chk("w_valid", 32'(ov4), 32'd1);
    chk("w_pc", pc4, 32'h1000);
    chk("w_inst", inst4, 32'hDEAD_BEEF);
    chk("w_we", 32'(we4), 32'd1);
    chk("w_waddr", waddr4, 32'h1000);
    chk("w_wdata", wdata4, 32'hDEAD_BEEF);
    tick();
    chk("w_next_req", 32'(req4), 32'd1);
    chk("w_next_addr", addr4, 32'h1004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
